// File: rtl/dma_pkg.sv
// Shared register map, control bit positions and per-channel state record
// for the multi-channel DMA address engine.
package dma_pkg;

   localparam logic [2:0] OFF_SRC_LO = 3'd0;
   localparam logic [2:0] OFF_SRC_HI = 3'd1;
   localparam logic [2:0] OFF_DST_LO = 3'd2;
   localparam logic [2:0] OFF_DST_HI = 3'd3;
   localparam logic [2:0] OFF_LEN    = 3'd4;
   localparam logic [2:0] OFF_CTRL   = 3'd5;
   localparam logic [2:0] OFF_REM    = 3'd6;

   localparam int CTRL_START  = 7;
   localparam int CTRL_IRQ_EN = 6;
   localparam int CTRL_ABORT  = 0;
   localparam int DST_DIR_BIT = 6;

   typedef struct packed {
      logic [15:0] src;
      logic [12:0] dst;
      logic        dir;
      logic [7:0]  len;
      logic [8:0]  rem;
      logic [7:0]  cnt;
      logic        busy;
      logic        done;
      logic        irq_en;
   } ch_regs_t;

   // A programmed length of 0 means 256 block units.
   function automatic logic [8:0] len_units(input logic [7:0] len);
      return (len == 8'd0) ? 9'd256 : {1'b0, len};
   endfunction

endpackage

// File: rtl/dma_channel.sv
// One DMA channel: CPU-visible register file, address/byte/block counters
// and the start/abort/done bookkeeping. The top decides when it transfers.
module dma_channel
   import dma_pkg::*;
#(
   parameter int BLOCK = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en_i,
   input  logic [2:0]  off_i,
   input  logic [7:0]  wdata_i,
   input  logic        xfer_i,
   output logic [15:0] src_o,
   output logic [12:0] dst_o,
   output logic        dir_o,
   output logic        busy_o,
   output logic        blk_end_o,
   output logic        irq_o,
   output logic [7:0]  rdata_o
);

   localparam logic [7:0] CNT_RELOAD = 8'(BLOCK - 1);

   ch_regs_t regs_q, regs_d;

   always_comb begin
      regs_d = regs_q;
      if (xfer_i) begin
         regs_d.src = regs_q.src + 16'd1;
         regs_d.dst = regs_q.dst + 13'd1;
         if (regs_q.cnt == 8'd0) begin
            regs_d.cnt = CNT_RELOAD;
            regs_d.rem = regs_q.rem - 9'd1;
            if (regs_q.rem == 9'd1) begin
               regs_d.busy = 1'b0;
               regs_d.done = 1'b1;
            end
         end else begin
            regs_d.cnt = regs_q.cnt - 8'd1;
         end
      end
      // Applied after the transfer update so a same-cycle CPU write takes precedence.
      if (wr_en_i) begin
         case (off_i)
            OFF_SRC_LO: if (!regs_q.busy) regs_d.src[7:0]  = wdata_i;
            OFF_SRC_HI: if (!regs_q.busy) regs_d.src[15:8] = wdata_i;
            OFF_DST_LO: if (!regs_q.busy) regs_d.dst[7:0]  = wdata_i;
            OFF_DST_HI: if (!regs_q.busy) begin
               regs_d.dst[12:8] = wdata_i[4:0];
               regs_d.dir       = wdata_i[DST_DIR_BIT];
            end
            OFF_LEN:    if (!regs_q.busy) regs_d.len = wdata_i;
            OFF_CTRL: begin
               regs_d.irq_en = wdata_i[CTRL_IRQ_EN];
               if (wdata_i[CTRL_ABORT]) begin
                  regs_d.busy = 1'b0;
               end else if (wdata_i[CTRL_START]) begin
                  regs_d.busy = 1'b1;
                  regs_d.done = 1'b0;
                  regs_d.cnt  = CNT_RELOAD;
                  regs_d.rem  = len_units(regs_q.len);
               end else begin
                  regs_d.done = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) regs_q <= '0;
      else       regs_q <= regs_d;
   end

   always_comb begin
      rdata_o = 8'h00;
      case (off_i)
         OFF_SRC_LO: rdata_o = regs_q.src[7:0];
         OFF_SRC_HI: rdata_o = regs_q.src[15:8];
         OFF_DST_LO: rdata_o = regs_q.dst[7:0];
         OFF_DST_HI: rdata_o = {1'b0, regs_q.dir, 1'b0, regs_q.dst[12:8]};
         OFF_LEN:    rdata_o = regs_q.len;
         OFF_CTRL:   rdata_o = {regs_q.busy, regs_q.irq_en, 5'b0, regs_q.done};
         OFF_REM:    rdata_o = regs_q.rem[7:0];
         default:    rdata_o = 8'h00;
      endcase
   end

   assign src_o     = regs_q.src;
   assign dst_o     = regs_q.dst;
   assign dir_o     = regs_q.dir;
   assign busy_o    = regs_q.busy;
   assign blk_end_o = (regs_q.cnt == 8'd0);
   assign irq_o     = regs_q.done & regs_q.irq_en;

endmodule

// File: rtl/dma_multi.sv
// Multi-channel DMA address engine: register window decode, LCD slot timer,
// block-locked priority arbiter and the address/readback output muxes.
module dma_multi
   import dma_pkg::*;
#(
   parameter int         NUM_CH   = 2,
   parameter int         BLOCK    = 16,
   parameter int         LCD_DIV  = 6,
   parameter logic [5:0] REG_BASE = 6'h08
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce,
   input  logic [5:0]  AB,
   input  logic        cpu_rwn,
   input  logic        dma_cs,
   input  logic        lcd_en,
   input  logic [7:0]  data_in,
   output logic [7:0]  cpu_dout,
   output logic [15:0] cbus_addr,
   output logic [12:0] vbus_addr,
   output logic        dma_dir,
   output logic        dma_en,
   output logic [1:0]  dma_ch,
   output logic        irq
);

   localparam logic [7:0] LCD_LAST = 8'(LCD_DIV - 1);

   logic [6:0]  rel;
   logic        win_hit;
   logic [1:0]  win_ch;
   logic        wr_strobe;

   logic [15:0] src_a   [NUM_CH];
   logic [12:0] dst_a   [NUM_CH];
   logic [7:0]  rdata_a [NUM_CH];
   logic [NUM_CH-1:0] dir_v, busy_v, blk_end_v, irq_v, xfer_v;

   logic [7:0]  lcd_div_q, lcd_div_d;
   logic        slot;
   logic        gnt_vld_q, gnt_vld_d;
   logic [1:0]  gnt_q, gnt_d;
   logic [1:0]  cur, low;
   logic        busy_any, gnt_busy, cur_blk_end;

   // Borrow in rel[6] means AB is below the window.
   assign rel       = {1'b0, AB} - {1'b0, REG_BASE};
   assign win_hit   = ~rel[6] & (rel[5:3] < 3'(NUM_CH));
   assign win_ch    = rel[4:3];
   assign wr_strobe = ~cpu_rwn & dma_cs & ce & win_hit;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign xfer_v[g] = dma_en & (cur == 2'(g));
      dma_channel #(.BLOCK(BLOCK)) u_ch (
         .clk       (clk),
         .reset     (reset),
         .wr_en_i   (wr_strobe & (win_ch == 2'(g))),
         .off_i     (rel[2:0]),
         .wdata_i   (data_in),
         .xfer_i    (xfer_v[g]),
         .src_o     (src_a[g]),
         .dst_o     (dst_a[g]),
         .dir_o     (dir_v[g]),
         .busy_o    (busy_v[g]),
         .blk_end_o (blk_end_v[g]),
         .irq_o     (irq_v[g]),
         .rdata_o   (rdata_a[g])
      );
   end

   assign slot = lcd_en & (lcd_div_q == LCD_LAST);

   // A held grant survives until its block ends; otherwise lowest busy index wins.
   always_comb begin
      busy_any = |busy_v;
      low      = 2'd0;
      gnt_busy = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (busy_v[i]) low = 2'(i);
      for (int i = 0; i < NUM_CH; i++)
         if (2'(i) == gnt_q) gnt_busy = busy_v[i];
      cur = (gnt_vld_q & gnt_busy) ? gnt_q : low;

      cbus_addr   = src_a[0];
      vbus_addr   = dst_a[0];
      dma_dir     = dir_v[0];
      cur_blk_end = blk_end_v[0];
      for (int i = 0; i < NUM_CH; i++)
         if (2'(i) == cur) begin
            cbus_addr   = src_a[i];
            vbus_addr   = dst_a[i];
            dma_dir     = dir_v[i];
            cur_blk_end = blk_end_v[i];
         end
   end

   assign dma_en = ce & busy_any & ~slot;
   assign dma_ch = cur;
   assign irq    = |irq_v;

   always_comb begin
      cpu_dout = 8'h00;
      for (int i = 0; i < NUM_CH; i++)
         if (win_hit && (win_ch == 2'(i))) cpu_dout = rdata_a[i];
   end

   always_comb begin
      lcd_div_d = lcd_div_q;
      gnt_vld_d = gnt_vld_q;
      gnt_d     = gnt_q;
      if (ce) lcd_div_d = (lcd_div_q == LCD_LAST) ? 8'd0 : lcd_div_q + 8'd1;
      if (dma_en) begin
         if (cur_blk_end) begin
            gnt_vld_d = 1'b0;
         end else begin
            gnt_vld_d = 1'b1;
            gnt_d     = cur;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lcd_div_q <= 8'd0;
         gnt_vld_q <= 1'b0;
         gnt_q     <= 2'd0;
      end else begin
         lcd_div_q <= lcd_div_d;
         gnt_vld_q <= gnt_vld_d;
         gnt_q     <= gnt_d;
      end
   end

endmodule

// File: tb/tb_dma_multi.sv
// Self-checking bench for dma_multi: directed scenarios plus randomized traffic,
// every cycle compared against a transfer-level reference model.
module tb_dma_multi;

   localparam int NUM_CH  = 2;
   localparam int BLOCK   = 16;
   localparam int LCD_DIV = 6;
   localparam int BASE    = 8;

   logic        clk = 1'b0;
   logic        reset, ce, cpu_rwn, dma_cs, lcd_en;
   logic [5:0]  AB;
   logic [7:0]  data_in;
   logic [7:0]  cpu_dout;
   logic [15:0] cbus_addr;
   logic [12:0] vbus_addr;
   logic        dma_dir, dma_en, irq;
   logic [1:0]  dma_ch;

   dma_multi #(.NUM_CH(NUM_CH), .BLOCK(BLOCK), .LCD_DIV(LCD_DIV), .REG_BASE(6'h08)) dut (
      .clk(clk), .reset(reset), .ce(ce), .AB(AB), .cpu_rwn(cpu_rwn), .dma_cs(dma_cs),
      .lcd_en(lcd_en), .data_in(data_in), .cpu_dout(cpu_dout), .cbus_addr(cbus_addr),
      .vbus_addr(vbus_addr), .dma_dir(dma_dir), .dma_en(dma_en), .dma_ch(dma_ch), .irq(irq)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: per-channel addresses, blocks left, position inside block.
   int m_src[NUM_CH], m_dst[NUM_CH], m_dir[NUM_CH], m_len[NUM_CH];
   int m_blocks[NUM_CH], m_pos[NUM_CH], m_busy[NUM_CH], m_done[NUM_CH], m_irqen[NUM_CH];
   int m_lock, m_div;

   bit   rec;
   int   q_ch[$];
   int   q_vb[$];
   logic last_en, last_irq;
   logic [7:0] last_dout;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NUM_CH; i++) begin
         m_src[i] = 0; m_dst[i] = 0; m_dir[i] = 0; m_len[i] = 0;
         m_blocks[i] = 0; m_pos[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_irqen[i] = 0;
      end
      m_lock = -1;
      m_div  = 0;
   endtask

   function automatic int mread(input int a);
      int rel, ch, off;
      rel = a - BASE;
      if (rel < 0 || rel >= 8 * NUM_CH) return 0;
      ch  = rel / 8;
      off = rel % 8;
      case (off)
         0: return m_src[ch] & 255;
         1: return m_src[ch] >> 8;
         2: return m_dst[ch] & 255;
         3: return (m_dir[ch] << 6) | (m_dst[ch] >> 8);
         4: return m_len[ch];
         5: return (m_busy[ch] << 7) | (m_irqen[ch] << 6) | m_done[ch];
         6: return m_blocks[ch] & 255;
         default: return 0;
      endcase
   endfunction

   task automatic idle();
      cpu_rwn = 1'b1;
      dma_cs  = 1'($urandom_range(0, 1));
      AB      = 6'($urandom_range(0, 63));
      data_in = 8'($urandom);
   endtask

   task automatic tick();
      int cur, low, rel, ch, off, d;
      bit any, slot, en, irqx;
      int bpre[NUM_CH];
      #1;
      slot = lcd_en && (m_div == LCD_DIV - 1);
      any = 0; low = 0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (m_busy[i] != 0) begin any = 1; low = i; end
      cur  = (m_lock >= 0 && m_busy[m_lock] != 0) ? m_lock : low;
      en   = ce && any && !slot;
      irqx = 0;
      for (int i = 0; i < NUM_CH; i++) if (m_done[i] != 0 && m_irqen[i] != 0) irqx = 1;
      check("dma_en", 32'(dma_en), 32'(en));
      check("cbus_addr", 32'(cbus_addr), m_src[cur]);
      check("vbus_addr", 32'(vbus_addr), m_dst[cur]);
      check("dma_dir", 32'(dma_dir), m_dir[cur]);
      check("dma_ch", 32'(dma_ch), cur);
      check("irq", 32'(irq), 32'(irqx));
      check("cpu_dout", 32'(cpu_dout), mread(int'(AB)));
      last_en = dma_en; last_irq = irq; last_dout = cpu_dout;
      if (rec && dma_en) begin q_ch.push_back(int'(dma_ch)); q_vb.push_back(int'(vbus_addr)); end

      if (reset) begin
         model_clear();
      end else if (ce) begin
         for (int i = 0; i < NUM_CH; i++) bpre[i] = m_busy[i];
         m_div = (m_div == LCD_DIV - 1) ? 0 : m_div + 1;
         if (en) begin
            m_src[cur] = (m_src[cur] + 1) % 65536;
            m_dst[cur] = (m_dst[cur] + 1) % 8192;
            if (m_pos[cur] == BLOCK - 1) begin
               m_pos[cur] = 0;
               m_blocks[cur]--;
               if (m_blocks[cur] == 0) begin m_busy[cur] = 0; m_done[cur] = 1; end
               m_lock = -1;
            end else begin
               m_pos[cur]++;
               m_lock = cur;
            end
         end
         rel = int'(AB) - BASE;
         if (!cpu_rwn && dma_cs && rel >= 0 && rel < 8 * NUM_CH) begin
            ch = rel / 8; off = rel % 8; d = int'(data_in);
            case (off)
               0: if (bpre[ch] == 0) m_src[ch] = (m_src[ch] & 16'hFF00) | d;
               1: if (bpre[ch] == 0) m_src[ch] = (m_src[ch] & 255) | (d << 8);
               2: if (bpre[ch] == 0) m_dst[ch] = (m_dst[ch] & 13'h1F00) | d;
               3: if (bpre[ch] == 0) begin
                  m_dst[ch] = (m_dst[ch] & 255) | ((d & 31) << 8);
                  m_dir[ch] = (d >> 6) & 1;
               end
               4: if (bpre[ch] == 0) m_len[ch] = d;
               5: begin
                  m_irqen[ch] = (d >> 6) & 1;
                  if ((d & 1) != 0) m_busy[ch] = 0;
                  else if ((d & 128) != 0) begin
                     m_busy[ch] = 1; m_done[ch] = 0; m_pos[ch] = 0;
                     m_blocks[ch] = (m_len[ch] == 0) ? 256 : m_len[ch];
                  end else m_done[ch] = 0;
               end
               default: ;
            endcase
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input int a, input int d);
      AB = 6'(a); cpu_rwn = 1'b0; dma_cs = 1'b1; data_in = 8'(d);
      tick();
      idle();
   endtask

   task automatic rd(input int a);
      AB = 6'(a); cpu_rwn = 1'b1; dma_cs = 1'b1;
      tick();
      idle();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int n, first, lastk, cyc, bad;
      reset = 1'b1; ce = 1'b1; lcd_en = 1'b0; rec = 1'b0;
      idle();
      model_clear();
      @(posedge clk);
      @(negedge clk);
      do_reset();

      // Two blocks back to back from 0x1234.
      wr(BASE + 0, 8'h34); wr(BASE + 1, 8'h12); wr(BASE + 2, 8'h00); wr(BASE + 3, 8'h01);
      wr(BASE + 4, 2); wr(BASE + 5, 8'h80);
      n = 0; first = -1; lastk = -1;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (last_en) begin n++; if (first < 0) first = k; lastk = k; end
      end
      check("t1_xfer_count", n, 32);
      check("t1_consecutive", lastk - first + 1, 32);
      rd(BASE + 5); check("t1_ctrl", 32'(last_dout), 32'h01);
      rd(BASE + 0); check("t1_src_lo", 32'(last_dout), 32'h54);
      rd(BASE + 1); check("t1_src_hi", 32'(last_dout), 32'h12);

      // LCD slot stealing: 16 transfers over 19 cycles.
      do_reset();
      lcd_en = 1'b1;
      wr(BASE + 0, 0); wr(BASE + 1, 0); wr(BASE + 2, 0); wr(BASE + 3, 0);
      wr(BASE + 4, 1); wr(BASE + 5, 8'h80);
      n = 0; cyc = 0;
      for (int k = 0; k < 60 && n < 16; k++) begin
         tick();
         cyc++;
         if (last_en) n++;
      end
      check("t2_xfers", n, 16);
      check("t2_cycles", cyc, 19);
      lcd_en = 1'b0;

      // Block-locked arbitration between two channels.
      do_reset();
      wr(BASE + 4, 1);
      wr(BASE + 8 + 4, 2);
      wr(BASE + 8 + 5, 8'h80);
      q_ch.delete(); rec = 1'b1;
      tick(); tick(); tick();
      wr(BASE + 5, 8'h80);
      for (int k = 0; k < 60; k++) tick();
      rec = 1'b0;
      check("t3_xfer_total", q_ch.size(), 48);
      bad = 0;
      for (int k = 0; k < q_ch.size(); k++)
         if (q_ch[k] != ((k >= 16 && k < 32) ? 0 : 1)) bad++;
      check("t3_ch_sequence", bad, 0);

      // 256 blocks with vbus wrap.
      do_reset();
      wr(BASE + 2, 8'hF0); wr(BASE + 3, 8'h1F); wr(BASE + 4, 0); wr(BASE + 5, 8'h80);
      q_vb.delete(); rec = 1'b1;
      for (int k = 0; k < 4300 && q_vb.size() < 4096; k++) tick();
      rec = 1'b0;
      check("t4_xfers", q_vb.size(), 4096);
      check("t4_vbus_first", (q_vb.size() > 16) ? q_vb[0] : -1, 32'h1FF0);
      check("t4_vbus_top", (q_vb.size() > 16) ? q_vb[15] : -1, 32'h1FFF);
      check("t4_vbus_wrap", (q_vb.size() > 16) ? q_vb[16] : -1, 32'h0000);
      tick(); tick();
      rd(BASE + 6); check("t4_remaining", 32'(last_dout), 0);
      rd(BASE + 5); check("t4_ctrl", 32'(last_dout), 32'h01);

      // Done interrupt, clear, and abort.
      do_reset();
      wr(BASE + 4, 1); wr(BASE + 5, 8'hC0);
      for (int k = 0; k < 20; k++) tick();
      check("t5_irq_set", 32'(last_irq), 1);
      wr(BASE + 5, 8'h40);
      tick();
      check("t5_irq_clear", 32'(last_irq), 0);
      rd(BASE + 5); check("t5_ctrl_cleared", 32'(last_dout), 32'h40);
      wr(BASE + 4, 2); wr(BASE + 5, 8'h80);
      for (int k = 0; k < 5; k++) tick();
      wr(BASE + 5, 8'h01);
      tick();
      check("t5_abort_en", 32'(last_en), 0);
      rd(BASE + 5); check("t5_abort_ctrl", 32'(last_dout), 32'h00);

      // Busy write protection, then reset mid-transfer.
      do_reset();
      wr(BASE + 0, 8'h11); wr(BASE + 4, 2); wr(BASE + 5, 8'h80);
      tick(); tick();
      wr(BASE + 3, 8'h5F); wr(BASE + 4, 7);
      rd(BASE + 3); check("t6_dsthi_locked", 32'(last_dout), 32'h00);
      rd(BASE + 4); check("t6_len_locked", 32'(last_dout), 2);
      reset = 1'b1; tick(); reset = 1'b0;
      tick();
      check("t6_en_after_reset", 32'(last_en), 0);
      bad = 0;
      for (int a = BASE; a < BASE + 8 * NUM_CH; a++) begin
         rd(a);
         if (last_dout != 8'h00) bad++;
      end
      check("t6_regs_zero", bad, 0);

      // Randomized traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         ce = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 49) == 0) lcd_en = ~lcd_en;
         reset = ($urandom_range(0, 699) == 0);
         if ($urandom_range(0, 5) == 0) begin
            AB      = 6'(6 + $urandom_range(0, 21));
            cpu_rwn = 1'b0;
            dma_cs  = ($urandom_range(0, 7) != 0);
            data_in = (AB[2:0] == 3'd4) ? 8'($urandom_range(0, 3)) : 8'($urandom);
         end else begin
            idle();
         end
         tick();
      end
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
